// File: rtl/thor2024_blend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : thor2024_blend_pipe
// Purpose  : Three-stage pipelined colour blender for the Thor2024 SIMD
//            execute path. Each transaction carries LANES packed pixels
//            laid out as {pad, r, g, b}, with b at the LSB. The block offers
//            four blend modes:
//              0 : weighted sum, saturating
//              1 : lerp
//              2 : additive, saturating
//              3 : modulate
//            Latency is fixed at 3 cycles and throughput is one transaction
//            per cycle. The whole pipeline advances on one global enable.
// Ports    : clk, rst_n (async active-low)
//            in_valid / in_ready   - input handshake
//            mode [1:0]            - blend mode, travels with the data
//            a, c0, c1             - weight and colour operand words
//            out_valid / out_ready - output handshake
//            o                     - blended pixels, pad bits forced to 0
//            sat_clr, sat_count    - saturation event counter; present only
//                                    when THOR2024_BLEND_SATCNT_EN is defined
// Option   : THOR2024_BLEND_SATCNT_EN adds the saturation counter ports and
//            logic.
// Revision : 1.0 - initial release
// ============================================================================
module thor2024_blend_pipe #(
  parameter int LANES = 2,
  parameter int CW    = 10,
  parameter int PW    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [LANES*PW-1:0]   a,
  input  logic [LANES*PW-1:0]   c0,
  input  logic [LANES*PW-1:0]   c1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*PW-1:0]   o
`ifdef THOR2024_BLEND_SATCNT_EN
  ,
  input  logic                  sat_clr,
  output logic [31:0]           sat_count
`endif
);

  localparam int c_NCOMP = 3 * LANES;   // components per transaction
  localparam int c_PRODW = 2 * CW + 1;  // widest product: (2x)*p
  localparam int c_SUMW  = 2 * CW + 2;  // sum of two products

  // --------------------------------------------------------------------------
  // Global advance and handshake
  // --------------------------------------------------------------------------
  logic       w_adv;
  logic       w_accept;
  logic       r_v1, r_v2, r_v3;
  logic [1:0] r_mode1, r_mode2;

  // The whole pipe moves together. It may advance whenever the output slot
  // is empty or is being drained in this cycle.
  assign w_adv     = ~r_v3 | out_ready;
  assign w_accept  = in_valid & w_adv;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_mode1 <= 2'd0;
      r_mode2 <= 2'd0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r_mode2 <= r_mode1;
      // The mode register loads only on a real accept. This keeps an
      // undriven mode bus from leaking into the pipe during idle cycles.
      if (in_valid) begin
        r_mode1 <= mode;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pad bits of the operands carry no information
  // --------------------------------------------------------------------------
  logic [LANES-1:0] w_unused_pad;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (PW > 3 * CW) begin : g_pad
      assign w_unused_pad[l] = ^{a [l*PW + 3*CW +: PW - 3*CW],
                                 c0[l*PW + 3*CW +: PW - 3*CW],
                                 c1[l*PW + 3*CW +: PW - 3*CW]};
    end else begin : g_nopad
      assign w_unused_pad[l] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Per-component datapath. Component k sits in lane k/3, slot k%3
  // (0 = b, 1 = g, 2 = r).
  // --------------------------------------------------------------------------
  logic [c_NCOMP-1:0][CW-1:0] w_res_all;
`ifdef THOR2024_BLEND_SATCNT_EN
  logic [c_NCOMP-1:0]         w_sat_all;
`endif

  for (genvar k = 0; k < c_NCOMP; k++) begin : g_comp
    localparam int c_LSB = (k / 3) * PW + (k % 3) * CW;

    logic [CW-1:0]      r_x, r_p, r_q;
    logic [CW-1:0]      w_nx, w_nq;
    logic [c_PRODW-1:0] w_pa, w_pb, r_pa, r_pb;
    logic [c_SUMW-1:0]  w_sum;
    logic [CW-1:0]      w_res, r_res;
    logic               w_sat;

    // S1: operand capture, on accept only
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x <= '0;
        r_p <= '0;
        r_q <= '0;
      end else if (w_accept) begin
        r_x <= a [c_LSB +: CW];
        r_p <= c0[c_LSB +: CW];
        r_q <= c1[c_LSB +: CW];
      end
    end

    assign w_nx = ~r_x;
    assign w_nq = ~r_q;

    // S2: each mode reduces to the sum of two terms. The additive mode
    // passes p and q through unchanged. Modulate uses only the first term.
    always_comb begin
      w_pa = '0;
      w_pb = '0;
      unique case (r_mode1)
        2'd0: begin
          w_pa = c_PRODW'({r_x, 1'b0}) * c_PRODW'(r_p);
          w_pb = c_PRODW'(r_x) * c_PRODW'({w_nq, 1'b0});
        end
        2'd1: begin
          w_pa = c_PRODW'(r_x) * c_PRODW'(r_p);
          w_pb = c_PRODW'(w_nx) * c_PRODW'(r_q);
        end
        2'd2: begin
          w_pa = c_PRODW'(r_p);
          w_pb = c_PRODW'(r_q);
        end
        default: begin
          w_pa = c_PRODW'(r_p) * c_PRODW'(r_q);
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pa <= '0;
        r_pb <= '0;
      end else if (w_adv) begin
        r_pa <= w_pa;
        r_pb <= w_pb;
      end
    end

    // S3: sum, then pick the result field and clamp where the mode can
    // overflow. Lerp and modulate are bounded by max*2^CW, so they never
    // clamp.
    assign w_sum = c_SUMW'(r_pa) + c_SUMW'(r_pb);

    always_comb begin
      w_sat = 1'b0;
      w_res = w_sum[2*CW-1:CW];
      unique case (r_mode2)
        2'd0: begin
          w_sat = |w_sum[c_SUMW-1:2*CW];
          w_res = w_sat ? {CW{1'b1}} : w_sum[2*CW-1:CW];
        end
        2'd2: begin
          w_sat = w_sum[CW];
          w_res = w_sat ? {CW{1'b1}} : w_sum[CW-1:0];
        end
        default: begin
          w_res = w_sum[2*CW-1:CW];
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_res <= '0;
      end else if (w_adv) begin
        r_res <= w_res;
      end
    end

    assign w_res_all[k] = r_res;

`ifdef THOR2024_BLEND_SATCNT_EN
    logic r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sat <= 1'b0;
      end else if (w_adv) begin
        r_sat <= w_sat;
      end
    end

    assign w_sat_all[k] = r_sat;
`endif
  end

  // --------------------------------------------------------------------------
  // Output packing: results go back into {pad, r, g, b} with zero pad
  // --------------------------------------------------------------------------
  always_comb begin
    o = '0;
    for (int l = 0; l < LANES; l++) begin
      o[l*PW +: 3*CW] = w_res_all[l*3 +: 3];
    end
  end

`ifdef THOR2024_BLEND_SATCNT_EN
  // --------------------------------------------------------------------------
  // Saturation event counter. It sticks at all-ones, and a clear wins over
  // a same-cycle increment.
  // --------------------------------------------------------------------------
  logic [31:0] w_inc;
  logic [32:0] w_cnt_next;
  logic [31:0] r_sat_count;

  always_comb begin
    w_inc = '0;
    for (int i = 0; i < c_NCOMP; i++) begin
      w_inc = w_inc + {31'd0, w_sat_all[i]};
    end
  end

  assign w_cnt_next = {1'b0, r_sat_count} + {1'b0, w_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (r_v3 & out_ready) begin
      r_sat_count <= w_cnt_next[32] ? 32'hFFFF_FFFF : w_cnt_next[31:0];
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thor2024_blend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_thor2024_blend_pipe
// Purpose  : Scoreboard bench for thor2024_blend_pipe.
//            - Stimulus pushes the hand-computed expected word for each
//              accepted transaction.
//            - A monitor pops and compares on every output handshake.
//            - The monitor also checks hold and back-pressure during stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thor2024_blend_pipe;

  localparam int LANES = 2;
  localparam int CW    = 10;
  localparam int PW    = 32;
  localparam int W     = LANES * PW;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [1:0]   mode      = 2'd0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] c0        = '0;
  logic [W-1:0] c1        = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] o;
`ifdef THOR2024_BLEND_SATCNT_EN
  logic         sat_clr   = 1'b0;
  logic [31:0]  sat_count;
`endif

  int errors = 0;
  int checks = 0;
  int sat_total = 0;

  logic [W-1:0] exp_q[$];
  int           sat_q[$];

  logic [1:0]   v_mode[4];
  logic [W-1:0] v_a[4], v_c0[4], v_c1[4], v_exp[4];
  int           v_sat[4];

  always #5 clk = ~clk;

  thor2024_blend_pipe #(.LANES(LANES), .CW(CW), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .c0        (c0),
    .c1        (c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
`ifdef THOR2024_BLEND_SATCNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
`endif
  );

  // Input pixels carry all-ones pad so that pad stripping is visible.
  function automatic logic [PW-1:0] pin(input logic [CW-1:0] r, input logic [CW-1:0] g,
                                        input logic [CW-1:0] b);
    return {{(PW-3*CW){1'b1}}, r, g, b};
  endfunction

  function automatic logic [PW-1:0] pout(input logic [CW-1:0] r, input logic [CW-1:0] g,
                                         input logic [CW-1:0] b);
    return {{(PW-3*CW){1'b0}}, r, g, b};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Vector tables: {lane1, lane0}
  initial begin
    // mode 0, weighted sum
    v_mode[0] = 2'd0;
    v_a[0]    = {pin(10'h100, 10'h3FF, 10'h100), pin(10'h200, 10'h3FF, 10'h000)};
    v_c0[0]   = {pin(10'h100, 10'h000, 10'h000), pin(10'h3FF, 10'h3FF, 10'h123)};
    v_c1[0]   = {pin(10'h3FF, 10'h3FF, 10'h000), pin(10'h3FF, 10'h000, 10'h000)};
    v_exp[0]  = {pout(10'h080, 10'h000, 10'h1FF), pout(10'h3FF, 10'h3FF, 10'h000)};
    v_sat[0]  = 1;
    // mode 1, lerp
    v_mode[1] = 2'd1;
    v_a[1]    = {pin(10'h100, 10'h000, 10'h3FF), pin(10'h000, 10'h3FF, 10'h200)};
    v_c0[1]   = {pin(10'h200, 10'h000, 10'h3FF), pin(10'h155, 10'h3FF, 10'h3FF)};
    v_c1[1]   = {pin(10'h100, 10'h000, 10'h3FF), pin(10'h3FF, 10'h3FF, 10'h000)};
    v_exp[1]  = {pout(10'h13F, 10'h000, 10'h3FE), pout(10'h3FE, 10'h3FE, 10'h1FF)};
    v_sat[1]  = 0;
    // mode 2, additive
    v_mode[2] = 2'd2;
    v_a[2]    = {pin(10'h3FF, 10'h3FF, 10'h3FF), pin(10'h3FF, 10'h3FF, 10'h3FF)};
    v_c0[2]   = {pin(10'h300, 10'h100, 10'h3FF), pin(10'h000, 10'h1FF, 10'h200)};
    v_c1[2]   = {pin(10'h200, 10'h080, 10'h001), pin(10'h000, 10'h200, 10'h200)};
    v_exp[2]  = {pout(10'h3FF, 10'h180, 10'h3FF), pout(10'h000, 10'h3FF, 10'h3FF)};
    v_sat[2]  = 3;
    // mode 3, modulate
    v_mode[3] = 2'd3;
    v_a[3]    = {pin(10'h000, 10'h000, 10'h000), pin(10'h000, 10'h000, 10'h000)};
    v_c0[3]   = {pin(10'h200, 10'h100, 10'h001), pin(10'h3FF, 10'h3FF, 10'h000)};
    v_c1[3]   = {pin(10'h200, 10'h3FF, 10'h001), pin(10'h200, 10'h3FF, 10'h3FF)};
    v_exp[3]  = {pout(10'h100, 10'h0FF, 10'h000), pout(10'h1FF, 10'h3FE, 10'h000)};
    v_sat[3]  = 0;
  end

  // Drive one transaction and return once it has been accepted. Inputs go X
  // afterwards.
  task automatic send(input int k);
    bit ok;
    bit acc;
    ok       = 1'b0;
    in_valid = 1'b1;
    mode     = v_mode[k];
    a        = v_a[k];
    c0       = v_c0[k];
    c1       = v_c1[k];
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back(v_exp[k]);
      sat_q.push_back(v_sat[k]);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: vector %0d not accepted in 200 cycles", k);
    end
    in_valid = 1'b0;
    mode     = 'x;
    a        = 'x;
    c0       = 'x;
    c1       = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending results, required=0", exp_q.size());
    end
  endtask

  // Monitor: scoreboard pop on handshake, plus stall hold and back-pressure
  initial begin
    logic         held;
    logic [W-1:0] held_o;
    logic [W-1:0] e;
    held = 1'b0;
    held_o = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checks++;
          if (out_valid !== 1'b1 || o !== held_o) begin
            errors++;
            $display("FAIL stall_hold: actual valid=%b o=%h required valid=1 o=%h",
                     out_valid, o, held_o);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          held = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: actual o=%h required no output", o);
          end else begin
            e = exp_q.pop_front();
            sat_total += sat_q.pop_front();
            if (o !== e) begin
              errors++;
              $display("FAIL result: actual=%h required=%h", o, e);
            end
          end
        end else if (out_valid === 1'b1) begin
          held   = 1'b1;
          held_o = o;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: actual=%b required=0", in_ready);
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit stale;

    // ---------------- reset state ----------------
    #12;
    check("reset_out_valid", W'(out_valid), W'(1'b0));
    check("reset_o", o, '0);
    check("reset_in_ready", W'(in_ready), W'(1'b1));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- single transactions, latency ----------------
    send(0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", W'(lat), W'(3));
    drain();
    send(1); drain();
    send(2); drain();
    send(3); drain();
`ifdef THOR2024_BLEND_SATCNT_EN
    check("sat_count_singles", W'(sat_count), W'(sat_total));
`endif

    // ---------------- back-to-back stream with a 4-cycle stall ----------------
    fork
      begin
        send(1); send(3); send(0); send(2);
        send(2); send(0); send(1); send(3);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
`ifdef THOR2024_BLEND_SATCNT_EN
    check("sat_count_stream", W'(sat_count), W'(sat_total));
`endif

    // ---------------- reset with two transactions in flight ----------------
    out_ready = 1'b0;
    send(0);
    send(2);
    @(posedge clk);
    #1;
    check("pre_reset_valid", W'(out_valid), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    sat_q.delete();
    check("async_reset_out_valid", W'(out_valid), W'(1'b0));
    check("async_reset_o", o, '0);
`ifdef THOR2024_BLEND_SATCNT_EN
    check("async_reset_sat_count", W'(sat_count), W'(0));
    sat_total = 0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    check("no_stale_after_reset", W'(stale), W'(1'b0));

    // ---------------- clear colliding with an increment ----------------
    @(posedge clk);
    #1;
    send(2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("clr_case_valid", W'(out_valid), W'(1'b1));
`ifdef THOR2024_BLEND_SATCNT_EN
    sat_clr = 1'b1;
`endif
    @(posedge clk);
    #1;
`ifdef THOR2024_BLEND_SATCNT_EN
    sat_clr = 1'b0;
    check("sat_clr_priority", W'(sat_count), W'(0));
`endif
    drain();
    send(2);
    drain();
`ifdef THOR2024_BLEND_SATCNT_EN
    check("sat_count_after_clr", W'(sat_count), W'(3));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/thor2024_blend_pipe.md
Name: thor2024_blend_pipe

Overview:
- Pipelined, parametrised colour blender for the Thor2024 graphics/SIMD execute path.
- Processes LANES packed pixels per transaction. Each pixel has three CW-bit components (r, g, b) plus pad bits.
- Four selectable blend modes; the legacy weighted-sum mode is mode 0.
- Valid/ready handshake on input and output, fixed 3-cycle latency, full throughput.

Parameters:
- LANES, 2, pixels per word
- CW, 10, bits per colour component
- PW, 32, bits per packed pixel; must be >= 3*CW. Layout {pad, r, g, b}, b at LSB.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- mode  in  2  blend mode, sampled with the input data
- a  in  LANES*PW  weight / alpha pixels
- c0  in  LANES*PW  colour operand 0
- c1  in  LANES*PW  colour operand 1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- o  out  LANES*PW  blended pixels; pad bits always 0
- sat_clr  in  1  (SATCNT only) clear saturation counter
- sat_count  out  32  (SATCNT only) saturation event count

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits 0, all pipeline data registers 0.
  - o = 0, out_valid = 0, sat_count = 0.
  - In-flight transactions are discarded; no output appears after reset release until new input is accepted.
- Pipeline is 3 stages:
  - S1 registers the operands and mode.
  - S2 forms the products.
  - S3 forms the sums, applies saturation and drives o/out_valid.
- Global advance enable: adv = ~v3 | out_ready. All stages move only when adv = 1.
- in_ready = adv. An input is accepted when in_valid & in_ready.
- Bubbles propagate as cleared valid bits. There is no bubble collapsing beyond the global-enable rule.
- Latency is exactly 3 cycles when out_ready is held high. Throughput is one transaction per cycle.
- While out_valid = 1 and out_ready = 0:
  - o and out_valid hold stable.
  - in_ready = 0.
- Simultaneous accept at input and output in the same cycle is legal; no loss, no duplication.
- Per component, with max = 2^CW-1, x = a comp, p = c0 comp, q = c1 comp, and ~ meaning CW-bit invert:
  - mode 0 (legacy weighted sum):
    - s = (2x)*p + x*(2*~q), computed at 2CW+2 bits.
    - result = (s[2CW+1:2CW] != 0) ? max : s[2CW-1:CW].
  - mode 1 (lerp):
    - s = x*p + (~x)*q, 2CW bits.
    - result = s[2CW-1:CW], truncating with no rounding. Never saturates.
  - mode 2 (additive):
    - s = p + q, CW+1 bits.
    - result = s[CW] ? max : s[CW-1:0].
  - mode 3 (modulate):
    - result = (p*q)[2CW-1:CW]. Never saturates.
- Lanes and components are independent; there is no carry between them.
- The mode value travels with its data, so a mode change between back-to-back transactions is legal.
- X on data inputs while in_valid = 0 must not propagate to o when out_valid = 1.

Optional Feature:
- Macro: THOR2024_BLEND_SATCNT_EN.
- Defined:
  - sat_clr/sat_count ports exist.
  - On each output handshake (out_valid & out_ready), sat_count increments by the number of components that saturated in that transaction, 0..3*LANES.
  - sat_count sticks at 32'hFFFFFFFF rather than wrapping.
  - sat_clr sets the count to 0 next cycle and takes priority over a same-cycle increment.
  - The per-component saturation flag is carried in S3 alongside the data.
- Undefined:
  - The ports are absent, with no counter logic or flags.
  - Datapath behaviour is unchanged.

Test Plan:
- Mode 0, CW=10, lane0 a.r=0x200, c0.r=0x3FF, c1.r=0x3FF, out_ready=1 -> o lane0 r=0x3FF (s=0xFFC00, no saturate), exactly 3 cycles after accept.
- Mode 0, a.g=0x3FF, c0.g=0x3FF, c1.g=0x000 -> g=0x3FF via saturation; with SATCNT_EN, sat_count +1.
- Mode 1, a.b=0x200, c0.b=0x3FF, c1.b=0 -> b=0x1FF. Mode 3, c0=0x3FF, c1=0x200 -> 0x1FF.
- Mode 2, lane1 c0.r=0x300, c1.r=0x200 -> 0x3FF; same cycle c0.g=0x100, c1.g=0x080 -> 0x180. Pad bits read 0.
- Back-to-back stream of 8 transactions with mixed modes:
  - out_ready low for 4 cycles mid-stream -> in_ready drops, o holds, all 8 results emerge in order, none lost or duplicated.
- Assert rst_n low with 2 transactions in flight -> out_valid, o and sat_count go 0 immediately. After release, no stale output appears. Then sat_clr and an increment in the same cycle -> count 0.
